// File: rtl/intdiv_iter.sv
// Iterative radix-2 restoring integer divider for the Execute stage.
// One quotient bit per cycle; divide-by-zero and signed overflow finish immediately.
module intdiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            IntDivE,
    input  logic            SignedE,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    input  logic            StallM,
    input  logic            FlushE,
    output logic            DivBusyE,
    output logic            DivDoneE,
    output logic [XLEN-1:0] QuotE,
    output logic [XLEN-1:0] RemE
);

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] quot_q, rem_q, dvs_q;
    logic            negq_q, negr_q;

    logic            StartE;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, sgn_ovf;
    logic [XLEN:0]   trial;
    logic            ge;
    logic [XLEN-1:0] quot_d, rem_d;
    logic            last_step;

    assign StartE   = (state_q == IDLE) & IntDivE & ~FlushE;
    assign sign_a   = SignedE & ForwardedSrcAE[XLEN-1];
    assign sign_b   = SignedE & ForwardedSrcBE[XLEN-1];
    assign abs_a    = sign_a ? -ForwardedSrcAE : ForwardedSrcAE;
    assign abs_b    = sign_b ? -ForwardedSrcBE : ForwardedSrcBE;
    assign div_zero = (ForwardedSrcBE == '0);
    assign sgn_ovf  = SignedE & (ForwardedSrcAE == {1'b1, {(XLEN-1){1'b0}}}) & (&ForwardedSrcBE);

    // Restoring step: bring in the next dividend bit, subtract only if it fits.
    always_comb begin
        trial  = {rem_q, quot_q[XLEN-1]};
        ge     = (trial >= {1'b0, dvs_q});
        rem_d  = ge ? (trial[XLEN-1:0] - dvs_q) : trial[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], ge};
    end

    assign last_step = (cnt_q == CW'(XLEN - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else if (FlushE) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (StartE) begin
                        if (div_zero) begin
                            quot_q  <= '1;
                            rem_q   <= ForwardedSrcAE;
                            negq_q  <= 1'b0;
                            negr_q  <= 1'b0;
                            state_q <= DONE;
                        end else if (sgn_ovf) begin
                            quot_q  <= ForwardedSrcAE;
                            rem_q   <= '0;
                            negq_q  <= 1'b0;
                            negr_q  <= 1'b0;
                            state_q <= DONE;
                        end else begin
                            quot_q  <= abs_a;
                            rem_q   <= '0;
                            dvs_q   <= abs_b;
                            negq_q  <= sign_a ^ sign_b;
                            negr_q  <= sign_a;
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    quot_q <= quot_d;
                    rem_q  <= rem_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (last_step) state_q <= DONE;
                end
                DONE: begin
                    if (!StallM) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DivBusyE = StartE | (state_q == BUSY);
    assign DivDoneE = (state_q == DONE);

    // Sign fix-up is applied on the way out so the iteration works on magnitudes only.
    assign QuotE = DivDoneE ? (negq_q ? -quot_q : quot_q) : '0;
    assign RemE  = DivDoneE ? (negr_q ? -rem_q : rem_q) : '0;

endmodule

// File: tb/tb_intdiv_iter.sv
// Directed bench for intdiv_iter: queued expected results checked when DivDoneE rises.
module tb_intdiv_iter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, IntDivE, SignedE, StallM, FlushE;
    logic [XLEN-1:0] ForwardedSrcAE, ForwardedSrcBE;
    logic            DivBusyE, DivDoneE;
    logic [XLEN-1:0] QuotE, RemE;

    int checks   = 0;
    int failures = 0;
    logic [2*XLEN-1:0] sbq[$];

    intdiv_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .IntDivE(IntDivE), .SignedE(SignedE),
        .ForwardedSrcAE(ForwardedSrcAE), .ForwardedSrcBE(ForwardedSrcBE),
        .StallM(StallM), .FlushE(FlushE), .DivBusyE(DivBusyE), .DivDoneE(DivDoneE),
        .QuotE(QuotE), .RemE(RemE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic sgn);
        logic [XLEN-1:0] q, r;
        if (b == '0) begin
            q = '1; r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else if (sgn) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one divide from IDLE; caller sets StallM beforehand when stall_cycles > 1.
    task automatic run_div(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic sgn, input logic [XLEN-1:0] eq, input logic [XLEN-1:0] er,
                           input int exp_busy, input int stall_cycles);
        int busy = 0;
        int n = 0;
        logic [2*XLEN-1:0] e;
        ForwardedSrcAE = a; ForwardedSrcBE = b; SignedE = sgn; IntDivE = 1'b1;
        sbq.push_back({eq, er});
        #1;
        check({tag, "_busy_start"}, 32'(DivBusyE), 32'd1);
        if (DivBusyE) busy++;
        tick();
        IntDivE = 1'b0; ForwardedSrcAE = $urandom; ForwardedSrcBE = $urandom; SignedE = ~sgn;
        while (!DivDoneE && n < 200) begin
            if (DivBusyE) busy++;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 32'(DivDoneE), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy), 32'(exp_busy));
        check({tag, "_busy_in_done"}, 32'(DivBusyE), 32'd0);
        e = sbq.pop_front();
        check({tag, "_quot"}, QuotE, e[2*XLEN-1:XLEN]);
        check({tag, "_rem"}, RemE, e[XLEN-1:0]);
        for (int i = 1; i < stall_cycles; i++) begin
            tick();
            check({tag, "_stall_done"}, 32'(DivDoneE), 32'd1);
            check({tag, "_stall_quot"}, QuotE, e[2*XLEN-1:XLEN]);
            check({tag, "_stall_rem"}, RemE, e[XLEN-1:0]);
        end
        StallM = 1'b0;
        tick();
        check({tag, "_idle_after"}, 32'(DivDoneE), 32'd0);
    endtask

    initial begin
        logic [2*XLEN-1:0] m;
        reset = 1'b1; IntDivE = 1'b0; SignedE = 1'b0; StallM = 1'b0; FlushE = 1'b0;
        ForwardedSrcAE = '0; ForwardedSrcBE = '0;
        tick(); tick();
        check("rst_busy", 32'(DivBusyE), 32'd0);
        check("rst_done", 32'(DivDoneE), 32'd0);
        check("rst_quot", QuotE, 32'd0);
        check("rst_rem", RemE, 32'd0);
        reset = 1'b0;
        tick();

        run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 1);
        run_div("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1);
        run_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 1);
        run_div("u5_0", 32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1, 1);
        run_div("sm5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 1);
        run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1, 1);
        m = model(32'hDEAD_BEEF, 32'h0000_1234, 1'b0);
        run_div("u_big", 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, m[63:32], m[31:0], 33, 1);
        m = model(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);
        run_div("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, m[63:32], m[31:0], 33, 1);
        m = model(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_div("u_ovfpat", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, m[63:32], m[31:0], 33, 1);
        m = model(32'd3, 32'd10, 1'b0);
        run_div("u3_10", 32'd3, 32'd10, 1'b0, m[63:32], m[31:0], 33, 1);

        // Flush on the tenth BUSY cycle.
        ForwardedSrcAE = 32'd100; ForwardedSrcBE = 32'd7; SignedE = 1'b0; IntDivE = 1'b1;
        tick();
        IntDivE = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        FlushE = 1'b1;
        #1;
        check("flush_busy_ungated", 32'(DivBusyE), 32'd1);
        tick();
        FlushE = 1'b0;
        #1;
        check("flush_busy", 32'(DivBusyE), 32'd0);
        check("flush_done", 32'(DivDoneE), 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("flush_no_done", 32'(DivDoneE), 32'd0);
        end
        run_div("after_flush", 32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 33, 1);

        // Results must hold while Memory is stalled.
        StallM = 1'b1;
        run_div("stall", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 5);

        // Reset on the twentieth BUSY cycle.
        ForwardedSrcAE = 32'hFFFF_FFF9; ForwardedSrcBE = 32'd2; SignedE = 1'b1; IntDivE = 1'b1;
        tick();
        IntDivE = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", 32'(DivBusyE), 32'd0);
        check("midrst_done", 32'(DivDoneE), 32'd0);
        check("midrst_quot", QuotE, 32'd0);
        check("midrst_rem", RemE, 32'd0);
        run_div("after_rst", 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1, 1);

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
